// File: rtl/fsm3_sched_pkg.sv
// fsm3_scheduler shared definitions.
// State encoding and count-width helper.
package fsm3_sched_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RST    = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_REPORT = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      RST    = ST_RST,
      STREAM = ST_STREAM,
      DRAIN  = ST_DRAIN,
      REPORT = ST_REPORT
   } sched_state_t;

   // Count width able to hold 0..len.
   function automatic int cw_of(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/fsm3_scheduler_rr_pick.sv
// Combinational round-robin picker.
// First set request at or above ptr, wrapping at N.
module rr_pick
   import fsm3_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] idx
);

   int   j;
   logic found;

   // Scan upward from ptr; first hit wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = PW'(j);
         end
      end
   end

endmodule

// File: rtl/fsm3_scheduler.sv
// Round-robin scheduler sharing one serial FSM.
// Streams a LEN-bit frame per grant and counts x/y.
module fsm3_scheduler
   import fsm3_sched_pkg::*;
#(
   parameter int N   = 4,
   parameter int LEN = 8,
   parameter int CW  = cw_of(LEN)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  bits,
   output logic [N-1:0]  grant,
   output logic          done,
   output logic [CW-1:0] x_count,
   output logic [CW-1:0] y_count,
   output logic          fsm_reset,
   output logic          fsm_a,
   input  logic          fsm_x,
   input  logic          fsm_y
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = $clog2(LEN);

   sched_state_t  state_q, state_d;
   logic [PW-1:0] ptr_q, g_q, pick_idx, ptr_nxt;
   logic [N-1:0]  grant_q, pick_oh;
   logic [KW-1:0] k_q;
   logic [CW-1:0] x_q, y_q;
   logic          last_bit;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );

   assign last_bit = (k_q == KW'(LEN - 1));
   assign ptr_nxt  = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: one frame is RST, LEN x STREAM, DRAIN, REPORT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|req) state_d = RST;
         RST:     state_d = STREAM;
         STREAM:  if (last_bit) state_d = DRAIN;
         DRAIN:   state_d = REPORT;
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant, pointer, bit counter and x/y accumulators.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         g_q     <= '0;
         grant_q <= '0;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req) begin
                  grant_q <= pick_oh;
                  g_q     <= pick_idx;
               end
            end
            RST: begin
               k_q <= '0;
               x_q <= '0;
               y_q <= '0;
            end
            STREAM: begin
               k_q <= k_q + KW'(1);
               // k=0 shows the FSM's reset state, not a frame bit
               if (k_q != '0) begin
                  x_q <= x_q + CW'(fsm_x);
                  y_q <= y_q + CW'(fsm_y);
               end
            end
            DRAIN: begin
               x_q <= x_q + CW'(fsm_x);
               y_q <= y_q + CW'(fsm_y);
            end
            REPORT: begin
               ptr_q   <= ptr_nxt;
               grant_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state.
   always_comb begin
      grant     = grant_q;
      done      = (state_q == REPORT);
      x_count   = x_q;
      y_count   = y_q;
      fsm_reset = reset | (state_q == RST);
      fsm_a     = (state_q == STREAM) & bits[g_q];
   end

endmodule

// File: tb/tb_fsm3_scheduler.sv
// fsm3_scheduler bench: shared FSM instance plus
// a frame-level reference model checked every cycle.
module tb_fsm3_scheduler;

   localparam int N   = 4;
   localparam int LEN = 8;
   localparam int CW  = $clog2(LEN + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req, bits, grant;
   logic          done, fsm_reset, fsm_a, fsm_x, fsm_y;
   logic [CW-1:0] x_count, y_count;
   logic [1:0]    fs;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   fsm3_scheduler #(.N(N), .LEN(LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .bits      (bits),
      .grant     (grant),
      .done      (done),
      .x_count   (x_count),
      .y_count   (y_count),
      .fsm_reset (fsm_reset),
      .fsm_a     (fsm_a),
      .fsm_x     (fsm_x),
      .fsm_y     (fsm_y)
   );

   // Shared FSM: a=1 counts mod 4, a=0 toggles between 0 and 1.
   always_ff @(posedge clk) begin
      if (fsm_reset) fs <= 2'd0;
      else if (fsm_a) fs <= fs + 2'd1;
      else fs <= {1'b0, ~fs[0]};
   end
   assign fsm_x = fs[0];
   assign fsm_y = fs[1];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // Reference model: ph 0 idle, 1 reset, 2..LEN+1 bits,
   // LEN+2 drain, LEN+3 report.
   int ph   = 0;
   int mptr = 0;
   int mg   = 0;
   int mxc  = 0;
   int myc  = 0;
   int mb[LEN];

   function automatic void frame_counts(output int xc, output int yc);
      int s;
      s  = 0;
      xc = 0;
      yc = 0;
      for (int i = 0; i < LEN; i++) begin
         if (mb[i] != 0) s = (s + 1) % 4;
         else s = (s % 2 == 0) ? 1 : 0;
         xc += s % 2;
         yc += s / 2;
      end
   endfunction

   task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] b,
                      input logic rs);
      logic [N-1:0] eg;
      logic         ea;
      @(negedge clk);
      req   = r;
      bits  = b;
      reset = rs;
      #1;
      eg = (ph >= 1) ? N'(1 << mg) : '0;
      ea = (ph >= 2 && ph <= LEN + 1) ? b[mg] : 1'b0;
      check("grant", 32'(grant), 32'(eg));
      check("done", 32'(done), 32'(ph == LEN + 3));
      check("fsm_a", 32'(fsm_a), 32'(ea));
      check("fsm_reset", 32'(fsm_reset), 32'(rs || ph == 1));
      if (ph == 0 || ph == LEN + 3) begin
         check("x_count", 32'(x_count), 32'(mxc));
         check("y_count", 32'(y_count), 32'(myc));
      end
      if (rs) begin
         ph   = 0;
         mptr = 0;
         mxc  = 0;
         myc  = 0;
      end else if (ph == 0) begin
         for (int i = 0; i < N; i++) begin
            if (r[(mptr + i) % N]) begin
               mg = (mptr + i) % N;
               ph = 1;
               break;
            end
         end
      end else if (ph == 1) begin
         mxc = 0;
         myc = 0;
         ph  = 2;
      end else if (ph <= LEN + 1) begin
         mb[ph - 2] = int'(b[mg]);
         ph++;
      end else if (ph == LEN + 2) begin
         frame_counts(mxc, myc);
         ph++;
      end else begin
         mptr = (mg + 1) % N;
         ph   = 0;
      end
   endtask

   task automatic run(input logic [N-1:0] r, input int n, input int bm);
      logic [N-1:0] b;
      for (int i = 0; i < n; i++) begin
         b = (bm == 0) ? '0 : (bm == 1) ? '1 : N'($urandom);
         cyc(r, b, 1'b0);
      end
   endtask

   initial begin
      logic [N-1:0] rr;
      req   = '0;
      bits  = '0;
      reset = 1'b1;
      cyc('0, '0, 1'b1);
      cyc('0, '0, 1'b1);
      run('0, 2, 2);
      // requester 0, all zeros
      run(4'b0001, 1, 0);
      run(4'b0000, LEN + 4, 0);
      // requester 2, all ones
      run(4'b0100, 1, 1);
      run(4'b0000, LEN + 4, 1);
      // all requesting: rotate through every line
      run(4'b1111, 5 * (LEN + 4), 2);
      run(4'b0000, 2, 2);
      // reset, frame on 1, then 1010 picks 3 before 1
      cyc('0, '0, 1'b1);
      run(4'b0010, 1, 2);
      run(4'b0000, LEN + 4, 2);
      run(4'b1010, 2 * (LEN + 4), 2);
      run(4'b0000, 2, 2);
      // req[1] dropped in third STREAM cycle
      run(4'b0010, 4, 2);
      run(4'b0000, LEN + 2, 2);
      // reset at k=4 of STREAM, then a normal frame
      run(4'b0001, 6, 2);
      cyc(4'b0001, 4'b1111, 1'b1);
      run(4'b0000, 3, 2);
      run(4'b0001, 1, 2);
      run(4'b0000, LEN + 4, 2);
      // random traffic with occasional reset
      rr = '0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(15) == 0) rr = N'($urandom);
         cyc(rr, N'($urandom), $urandom_range(199) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fsm3_scheduler.md
# fsm3_scheduler

Round-robin scheduler that shares one two-bit serial FSM (input `a`, Moore outputs `x`/`y`) among N requesters. Each granted requester streams a fixed-length frame of bits through the shared FSM. The scheduler resets the FSM before each frame, drives its `a` input from the granted requester's bit line, counts `x` and `y` assertions over the frame, and returns both counts with a one-cycle `done` pulse. It sits between the requester ports and the single shared FSM instance.

## Interface
- `N`, default 4: number of requesters.
- `LEN`, default 8: bits per frame, must be ≥ 2.
- `CW`, default `$clog2(LEN+1)`: count width.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  N  per-requester request, level.
- `bits`  in  N  per-requester serial data bit, sampled during STREAM.
- `grant`  out  N  one-hot grant, held for the whole frame; 0 when idle.
- `done`  out  1  one-cycle pulse in REPORT; counts valid.
- `x_count`  out  CW  number of frame samples with `fsm_x`=1.
- `y_count`  out  CW  number of frame samples with `fsm_y`=1.
- `fsm_reset`  out  1  reset to the shared FSM.
- `fsm_a`  out  1  `a` input to the shared FSM.
- `fsm_x`  in  1  `x` output of the shared FSM.
- `fsm_y`  in  1  `y` output of the shared FSM.

## Operation
- States: IDLE, RST, STREAM, DRAIN, REPORT.
- IDLE: if `req` ≠ 0, pick the first set bit searching upward from `ptr`, wrapping at N. Register its one-hot into `grant`, then go to RST. Otherwise stay in IDLE.
- RST: `fsm_reset`=1 for exactly one cycle. Clear `x_count`/`y_count` and the bit counter `k`. Go to STREAM.
- STREAM: lasts LEN cycles, k = 0..LEN-1.
  - `fsm_a` = `bits[g]`, where g is the granted index.
  - For k ≥ 1, add `fsm_x` to `x_count` and `fsm_y` to `y_count`.
  - After k = LEN-1, go to DRAIN.
- DRAIN: one cycle. Sample `fsm_x`/`fsm_y` once more, reflecting the last bit. Go to REPORT.
- REPORT: `done`=1. Set `ptr` = g+1 mod N. Go to IDLE. `grant` drops on the IDLE entry.
- Per frame, exactly LEN samples are counted, one per bit. Counts never exceed LEN and never wrap.
- `fsm_a`=0 outside STREAM.
- `fsm_reset` = `reset` OR (state == RST), so the shared FSM is reset whenever the scheduler is.
- Deasserting `req[g]` mid-frame is ignored; the frame completes. `req` changes on other lines do not affect the current frame.
- Counts hold their values from REPORT until the next RST.

## Timing
- Reset values: state IDLE, `ptr` 0, `grant` 0, `done` 0, `x_count` 0, `y_count` 0, `fsm_a` 0, `fsm_reset` 1 while `reset` is high.
- `req` seen in IDLE at cycle t gives:
  - `grant` and RST at t+1;
  - STREAM at t+2 through t+1+LEN;
  - DRAIN at t+2+LEN;
  - `done` at t+3+LEN;
  - IDLE at t+4+LEN.
- Frame-to-frame spacing is LEN+4 cycles.
- `grant` is stable and one-hot from RST through REPORT.
- `reset` mid-frame: next cycle is IDLE with all outputs at reset values and no `done`. `ptr` returns to 0.

## Structure
- Shared package `fsm3_sched_pkg` holds:
  - state encoding localparams: IDLE=0, RST=1, STREAM=2, DRAIN=3, REPORT=4, 3 bits;
  - the `CW` helper function.
- Sub-module `rr_pick`: combinational N-bit round-robin picker. Inputs: `req`, `ptr`. Outputs: one-hot grant and binary index.
- The shared FSM is instantiated outside this block; the bench instantiates it alongside.

## Test plan
- Single requester 0, `bits`=0 for all 8 cycles (N=4, LEN=8) → grant=0001, `done` at t+11, x_count=4, y_count=0.
- Requester 2, `bits`=1 for all 8 cycles → grant=0100, x_count=4, y_count=4.
- `req`=1111 held continuously → grants cycle 0001, 0010, 0100, 1000, 0001, each frame exactly 12 cycles apart.
- `req`=1010 with `ptr`=2 after a frame on requester 1 → next grant 1000, then 0010.
- `req[1]` dropped in the third STREAM cycle → frame still completes, `done` pulses, `grant` held until REPORT.
- `reset` asserted in cycle k=4 of STREAM → next cycle grant=0, `done` never pulses, counts 0, `fsm_reset`=1 during reset; the following `req`=0001 produces a normal frame.
